usrt_rx_buffer: RTL and testbench

Receive-side buffer between the USRT deserializer and the APB bus. Accepts completed bytes from the deserializer, stores them in a small FIFO, and lets the APB master pop them through a memory-mapped DATA register. Sticky status flags record overrun and parity errors. A level interrupt tells software that data or an error is pending.

---
 rtl/usrt_rx_buffer.sv | 123 ++++++++++++
 tb/tb_usrt_rx_buffer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/usrt_rx_buffer.sv
// Receive buffer between the USRT deserializer and APB: a small byte FIFO
// with sticky overrun/parity flags, a CTRL register and a level interrupt.
module usrt_rx_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8
) (
  input  logic              pClk,
  input  logic              pReset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              rx_perr,
  input  logic              pSelect,
  input  logic              pEnable,
  input  logic              pWrite,
  input  logic [ADDR_W-1:0] pAddr,
  input  logic [7:0]        pWData,
  output logic [7:0]        pRData,
  output logic              pReady,
  output logic              pSlverr,
  output logic              rx_irq
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  localparam logic [1:0] SEL_DATA   = 2'd0;
  localparam logic [1:0] SEL_STATUS = 2'd1;
  localparam logic [1:0] SEL_CTRL   = 2'd2;
  localparam logic [1:0] SEL_FLUSH  = 2'd3;

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        ovr_q, ovr_d;
  logic        perr_q, perr_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic        irq_q, irq_d;
  logic [7:0]  mem_q [DEPTH];

  logic [AW:0] count;
  logic        empty, full, mapped;
  logic [1:0]  sel;
  logic        access, wr_acc, rd_acc;
  logic        pop, flush, ovr_clr, perr_clr;
  logic        push_req, push_ok, ovr_set, perr_set;
  logic        unused_bits;

  assign pReady      = 1'b1;
  assign sel         = pAddr[3:2];
  assign mapped      = ((pAddr >> 4) == '0);
  assign count       = wr_ptr_q - rd_ptr_q;
  assign empty       = (wr_ptr_q == rd_ptr_q);
  assign full        = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign pSlverr     = pSelect & pEnable & ~mapped;
  assign rx_irq      = irq_q;
  assign unused_bits = ^{pWData[7:4], pAddr[1:0]};

  always_comb begin
    access   = pSelect & pEnable & pReady;
    wr_acc   = access & pWrite & mapped;
    rd_acc   = access & ~pWrite & mapped;
    pop      = rd_acc & (sel == SEL_DATA) & ~empty;
    flush    = wr_acc & (sel == SEL_FLUSH);
    ovr_clr  = wr_acc & (sel == SEL_STATUS) & pWData[2];
    perr_clr = wr_acc & (sel == SEL_STATUS) & pWData[3];

    // A flush on the same edge swallows the incoming byte silently.
    push_req = rx_valid & ctrl_q[0] & ~flush;
    perr_set = push_req & rx_perr;
    ovr_set  = push_req & ~rx_perr & full & ~pop;
    push_ok  = push_req & ~rx_perr & ~(full & ~pop);

    rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    wr_ptr_d = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      wr_ptr_d = wr_ptr_q;
    end

    // Set beats a simultaneous write-one-to-clear.
    ovr_d  = (ovr_q & ~ovr_clr) | ovr_set;
    perr_d = (perr_q & ~perr_clr) | perr_set;
    ctrl_d = (wr_acc && sel == SEL_CTRL) ? pWData[1:0] : ctrl_q;
    irq_d  = ctrl_q[1] & (~empty | ovr_q | perr_q);
  end

  always_ff @(posedge pClk or posedge pReset) begin
    if (pReset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovr_q    <= 1'b0;
      perr_q   <= 1'b0;
      ctrl_q   <= 2'b01;
      irq_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovr_q    <= ovr_d;
      perr_q   <= perr_d;
      ctrl_q   <= ctrl_d;
      irq_q    <= irq_d;
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge pClk) begin
    if (push_ok && !pReset) begin
      mem_q[wr_ptr_q[AW-1:0]] <= rx_data;
    end
  end

  always_comb begin
    pRData = 8'h00;
    if (mapped) begin
      case (sel)
        SEL_DATA:   pRData = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
        SEL_STATUS: pRData = {4'(count), perr_q, ovr_q, full, ~empty};
        SEL_CTRL:   pRData = {6'b0, ctrl_q};
        default:    pRData = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_usrt_rx_buffer.sv
// Directed bench for usrt_rx_buffer (DEPTH=4): APB register access, FIFO
// ordering, overrun/parity flags, interrupt latency, flush and reset.
module tb_usrt_rx_buffer;

  logic       pClk = 1'b0;
  logic       pReset = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_perr = 1'b0;
  logic       pSelect = 1'b0;
  logic       pEnable = 1'b0;
  logic       pWrite = 1'b0;
  logic [7:0] pAddr = 8'h00;
  logic [7:0] pWData = 8'h00;
  logic [7:0] pRData;
  logic       pReady;
  logic       pSlverr;
  logic       rx_irq;

  int errors = 0;
  int checks = 0;

  usrt_rx_buffer #(.DEPTH(4), .ADDR_W(8)) dut (
    .pClk(pClk), .pReset(pReset),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_perr(rx_perr),
    .pSelect(pSelect), .pEnable(pEnable), .pWrite(pWrite),
    .pAddr(pAddr), .pWData(pWData), .pRData(pRData),
    .pReady(pReady), .pSlverr(pSlverr), .rx_irq(rx_irq)
  );

  always #5 pClk = ~pClk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  // One APB transfer; optionally pulses rx_valid on the completing edge.
  task automatic apb(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                     input logic push, input logic [7:0] pbyte,
                     output logic [7:0] rdata, output logic slverr);
    @(negedge pClk);
    pSelect = 1'b1; pEnable = 1'b0; pWrite = wr; pAddr = addr; pWData = wdata;
    @(negedge pClk);
    pEnable = 1'b1;
    if (push) begin
      rx_valid = 1'b1; rx_data = pbyte; rx_perr = 1'b0;
    end
    #1;
    rdata  = pRData;
    slverr = pSlverr;
    @(negedge pClk);
    pSelect = 1'b0; pEnable = 1'b0; pWrite = 1'b0; rx_valid = 1'b0;
    $display("apb %s addr=0x%02h wdata=0x%02h rdata=0x%02h push=%0b slverr=%0b",
             wr ? "wr" : "rd", addr, wdata, rdata, push, slverr);
  endtask

  task automatic rd(input logic [7:0] addr, output logic [7:0] data);
    logic s;
    apb(1'b0, addr, 8'h00, 1'b0, 8'h00, data, s);
  endtask

  task automatic wr(input logic [7:0] addr, input logic [7:0] data);
    logic [7:0] d;
    logic s;
    apb(1'b1, addr, data, 1'b0, 8'h00, d, s);
  endtask

  task automatic push(input logic [7:0] b, input logic perr);
    @(negedge pClk);
    rx_valid = 1'b1; rx_data = b; rx_perr = perr;
    @(negedge pClk);
    rx_valid = 1'b0; rx_perr = 1'b0;
    $display("rx byte=0x%02h perr=%0b", b, perr);
  endtask

  logic [7:0] d;
  logic       s;

  initial begin
    #1 pReset = 1'b1;
    repeat (3) @(negedge pClk);
    check("reset_irq", {7'b0, rx_irq}, 8'h00);
    check("reset_ready", {7'b0, pReady}, 8'h01);
    pReset = 1'b0;

    apb(1'b0, 8'h08, 8'h00, 1'b0, 8'h00, d, s);
    check("reset_ctrl", d, 8'h01);
    check("reset_slverr", {7'b0, s}, 8'h00);
    rd(8'h04, d); check("reset_status", d, 8'h00);

    // Ordering and count
    push(8'hA5, 1'b0);
    push(8'h3C, 1'b0);
    rd(8'h04, d); check("status_cnt2", d, 8'h21);
    rd(8'h00, d); check("data_a5", d, 8'hA5);
    rd(8'h04, d); check("status_cnt1", d, 8'h11);
    rd(8'h00, d); check("data_3c", d, 8'h3C);
    rd(8'h04, d); check("status_cnt0", d, 8'h00);
    rd(8'h00, d); check("data_empty", d, 8'h00);
    rd(8'h04, d); check("status_empty_rd", d, 8'h00);

    // Overrun: count 4, overrun, full, not_empty
    for (int i = 0; i < 5; i++) push(8'h10 + 8'(i), 1'b0);
    rd(8'h04, d); check("status_ovr", d, 8'h47);
    wr(8'h04, 8'h04);
    rd(8'h04, d); check("status_ovr_clr", d, 8'h43);

    // Push on the same edge as a pop while full
    apb(1'b0, 8'h00, 8'h00, 1'b1, 8'h77, d, s);
    check("data_10_pushpop", d, 8'h10);
    rd(8'h04, d); check("status_pushpop", d, 8'h43);
    for (int i = 1; i < 4; i++) begin
      rd(8'h00, d); check("data_drain", d, 8'h10 + 8'(i));
    end
    rd(8'h00, d); check("data_77", d, 8'h77);
    rd(8'h04, d); check("status_drained", d, 8'h00);

    // Parity error and interrupt timing
    push(8'hFF, 1'b1);
    rd(8'h04, d); check("status_perr", d, 8'h08);
    rd(8'h00, d); check("data_perr_dropped", d, 8'h00);
    check("irq_disabled", {7'b0, rx_irq}, 8'h00);
    wr(8'h08, 8'h03);
    check("irq_not_yet", {7'b0, rx_irq}, 8'h00);
    @(negedge pClk);
    check("irq_perr", {7'b0, rx_irq}, 8'h01);
    wr(8'h04, 8'h08);
    check("irq_hold", {7'b0, rx_irq}, 8'h01);
    @(negedge pClk);
    check("irq_cleared", {7'b0, rx_irq}, 8'h00);

    push(8'h55, 1'b0);
    check("irq_push_lat0", {7'b0, rx_irq}, 8'h00);
    @(negedge pClk);
    check("irq_push_lat1", {7'b0, rx_irq}, 8'h01);
    rd(8'h00, d); check("data_55", d, 8'h55);

    // rx_en=0 ignores bytes and flags
    wr(8'h08, 8'h02);
    push(8'h33, 1'b0);
    push(8'h44, 1'b1);
    rd(8'h04, d); check("status_rx_dis", d, 8'h00);
    wr(8'h08, 8'hFD);
    rd(8'h08, d); check("ctrl_mask", d, 8'h01);

    // Flush coinciding with a push
    push(8'h01, 1'b0);
    push(8'h02, 1'b0);
    apb(1'b1, 8'h0C, 8'h00, 1'b1, 8'h99, d, s);
    rd(8'h04, d); check("status_flush", d, 8'h00);
    rd(8'h0C, d); check("flush_read", d, 8'h00);

    // Writes to DATA are ignored
    push(8'h66, 1'b0);
    wr(8'h00, 8'h12);
    rd(8'h00, d); check("data_wr_ignored", d, 8'h66);

    // Unmapped addresses
    apb(1'b0, 8'h10, 8'h00, 1'b0, 8'h00, d, s);
    check("unmapped_rdata", d, 8'h00);
    check("unmapped_slverr", {7'b0, s}, 8'h01);
    apb(1'b1, 8'h18, 8'h00, 1'b0, 8'h00, d, s);
    check("unmapped_wr_slverr", {7'b0, s}, 8'h01);
    rd(8'h08, d); check("ctrl_after_unmapped", d, 8'h01);

    // Reset in the middle of a DATA read
    wr(8'h08, 8'h03);
    push(8'h42, 1'b0);
    push(8'h43, 1'b0);
    @(negedge pClk);
    check("irq_before_reset", {7'b0, rx_irq}, 8'h01);
    pSelect = 1'b1; pEnable = 1'b0; pWrite = 1'b0; pAddr = 8'h00;
    @(negedge pClk);
    pEnable = 1'b1;
    #1;
    check("head_before_reset", pRData, 8'h42);
    pReset = 1'b1;
    #1;
    check("reset_mid_rdata", pRData, 8'h00);
    check("reset_mid_irq", {7'b0, rx_irq}, 8'h00);
    @(negedge pClk);
    pSelect = 1'b0; pEnable = 1'b0;
    @(negedge pClk);
    pReset = 1'b0;
    $display("reset pulse during DATA read");
    rd(8'h04, d); check("status_after_reset", d, 8'h00);
    rd(8'h08, d); check("ctrl_after_reset", d, 8'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
